// File: rtl/jesd204b_pkg.sv
// Shared JESD204B definitions: control octets, link state codes (same codes as the RX core)
// and the ILAS configuration checksum.
package jesd204b_pkg;

    localparam logic [7:0] K285 = 8'hBC;
    localparam logic [7:0] K280 = 8'h1C;
    localparam logic [7:0] K283 = 8'h7C;
    localparam logic [7:0] K284 = 8'h9C;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_CGS       = 3'b001,
        ST_WAIT_LMFC = 3'b010,
        ST_ILAS      = 3'b011,
        ST_DATA      = 3'b100
    } link_state_t;

    // Octets 11 and 12 are reserved zeros, so only 0..10 contribute to the sum.
    function automatic logic [7:0] jesd_fchk(
        input logic [7:0] did, input logic [7:0] bid, input logic [7:0] lid,
        input logic [7:0] l, input logic [7:0] f, input logic [7:0] k,
        input logic [7:0] m, input logic [7:0] cs_n, input logic [7:0] subv_np,
        input logic [7:0] jesdv_s, input logic [7:0] cf_hd
    );
        logic [7:0] sum;
        sum = did + bid + lid + l + f + k + m + cs_n + subv_np + jesdv_s + cf_hd;
        return sum;
    endfunction

endpackage

// File: rtl/jesd204b_tx_ilas_rom.sv
// Combinational ILAS octet lookup: maps (multiframe index, octet position) to {octet, k flag}.
module jesd204b_tx_ilas_rom
    import jesd204b_pkg::*;
#(
    parameter int         JESD_F               = 1,
    parameter int         JESD_K               = 32,
    parameter int         LMFC_CNT_WIDTH       = 8,
    parameter logic [7:0] JESD204B_CONFIG_DID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_BID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_LID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_L       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_F       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_K       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_M       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_CS_N    = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_SUBV_NP = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_JESDV_S = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_CF_HD   = 8'h00
) (
    input  logic [1:0]                i_ilas_mf,
    input  logic [LMFC_CNT_WIDTH+1:0] i_pos,
    output logic [7:0]                o_octet,
    output logic                      o_k
);

    localparam int               P_W    = LMFC_CNT_WIDTH + 2;
    localparam logic [P_W-1:0]   P_LAST = P_W'(JESD_F * JESD_K - 1);
    localparam logic [7:0]       FCHK   = jesd_fchk(
        JESD204B_CONFIG_DID, JESD204B_CONFIG_BID, JESD204B_CONFIG_LID, JESD204B_CONFIG_L,
        JESD204B_CONFIG_F, JESD204B_CONFIG_K, JESD204B_CONFIG_M, JESD204B_CONFIG_CS_N,
        JESD204B_CONFIG_SUBV_NP, JESD204B_CONFIG_JESDV_S, JESD204B_CONFIG_CF_HD);

    logic [7:0] pos8;
    assign pos8 = 8'(i_pos);

    always_comb begin
        o_octet = pos8;
        o_k     = 1'b0;
        if (i_pos == '0) begin
            o_octet = K280;
            o_k     = 1'b1;
        end else if (i_pos == P_LAST) begin
            o_octet = K283;
            o_k     = 1'b1;
        end else if (i_ilas_mf == 2'd1 && i_pos == P_W'(1)) begin
            o_octet = K284;
            o_k     = 1'b1;
        end else if (i_ilas_mf == 2'd1 && i_pos <= P_W'(15)) begin
            // Config octet index is position - 2; indices 11 and 12 are reserved zeros.
            case (pos8)
                8'd2:    o_octet = JESD204B_CONFIG_DID;
                8'd3:    o_octet = JESD204B_CONFIG_BID;
                8'd4:    o_octet = JESD204B_CONFIG_LID;
                8'd5:    o_octet = JESD204B_CONFIG_L;
                8'd6:    o_octet = JESD204B_CONFIG_F;
                8'd7:    o_octet = JESD204B_CONFIG_K;
                8'd8:    o_octet = JESD204B_CONFIG_M;
                8'd9:    o_octet = JESD204B_CONFIG_CS_N;
                8'd10:   o_octet = JESD204B_CONFIG_SUBV_NP;
                8'd11:   o_octet = JESD204B_CONFIG_JESDV_S;
                8'd12:   o_octet = JESD204B_CONFIG_CF_HD;
                8'd15:   o_octet = FCHK;
                default: o_octet = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/jesd204b_tx_core.sv
// Single-lane JESD204B subclass-1 TX link layer: SYSREF-aligned LMFC, CGS, 4-multiframe ILAS,
// then user data pass-through to the transceiver.
module jesd204b_tx_core
    import jesd204b_pkg::*;
#(
    parameter int         JESD_F               = 1,
    parameter int         JESD_K               = 32,
    parameter int         LMFC_CNT_WIDTH       = 8,
    parameter logic [7:0] JESD204B_CONFIG_DID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_BID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_LID     = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_L       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_F       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_K       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_M       = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_CS_N    = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_SUBV_NP = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_JESDV_S = 8'h00,
    parameter logic [7:0] JESD204B_CONFIG_CF_HD   = 8'h00
) (
    input  logic        i_gtwiz_reset_clk_freerun_in,
    input  logic        i_gtwiz_reset_all_in,
    input  logic        i_sysref,
    input  logic        i_nsync,
    input  logic        i_tx_ready,
    input  logic [31:0] i_tx_data,
    output logic        o_tx_data_ready,
    output logic [31:0] o_gtwiz_userdata_tx_in,
    output logic [3:0]  o_txctrl2,
    output logic [2:0]  o_link_state,
    output logic        o_lmfc,
    output logic        o_sysref_done
);

    localparam int                        MFW       = JESD_F * JESD_K / 4;
    localparam logic [LMFC_CNT_WIDTH-1:0] LMFC_LAST = LMFC_CNT_WIDTH'(MFW - 1);

    logic                      sysref_q, sysref_d;
    logic                      sysref_done_q, sysref_done_d;
    logic [LMFC_CNT_WIDTH-1:0] lmfc_cnt_q, lmfc_cnt_d;
    logic                      nsync_meta_q, nsync_meta_d;
    logic                      nsync_s_q, nsync_s_d;
    logic                      nsync_low_q, nsync_low_d;
    link_state_t               state_q, state_d;
    logic [1:0]                ilas_mf_q, ilas_mf_d;
    logic [31:0]               tx_word_q, tx_word_d;
    logic [3:0]                txctrl_q, txctrl_d;
    logic                      lmfc_pulse_q, lmfc_pulse_d;
    logic                      tx_data_ready_q, tx_data_ready_d;

    logic        lmfc_wrap;
    logic        fall_back;
    logic [31:0] ilas_word;
    logic [3:0]  ilas_k;

    for (genvar n = 0; n < 4; n++) begin : g_oct
        jesd204b_tx_ilas_rom #(
            .JESD_F                  (JESD_F),
            .JESD_K                  (JESD_K),
            .LMFC_CNT_WIDTH          (LMFC_CNT_WIDTH),
            .JESD204B_CONFIG_DID     (JESD204B_CONFIG_DID),
            .JESD204B_CONFIG_BID     (JESD204B_CONFIG_BID),
            .JESD204B_CONFIG_LID     (JESD204B_CONFIG_LID),
            .JESD204B_CONFIG_L       (JESD204B_CONFIG_L),
            .JESD204B_CONFIG_F       (JESD204B_CONFIG_F),
            .JESD204B_CONFIG_K       (JESD204B_CONFIG_K),
            .JESD204B_CONFIG_M       (JESD204B_CONFIG_M),
            .JESD204B_CONFIG_CS_N    (JESD204B_CONFIG_CS_N),
            .JESD204B_CONFIG_SUBV_NP (JESD204B_CONFIG_SUBV_NP),
            .JESD204B_CONFIG_JESDV_S (JESD204B_CONFIG_JESDV_S),
            .JESD204B_CONFIG_CF_HD   (JESD204B_CONFIG_CF_HD)
        ) u_rom (
            .i_ilas_mf (ilas_mf_q),
            .i_pos     ({lmfc_cnt_q, 2'(n)}),
            .o_octet   (ilas_word[8*n +: 8]),
            .o_k       (ilas_k[n])
        );
    end

    // Only the first SYSREF edge after reset or after i_tx_ready returns aligns the LMFC.
    always_comb begin
        sysref_d      = i_sysref;
        lmfc_wrap     = (lmfc_cnt_q == LMFC_LAST);
        lmfc_cnt_d    = lmfc_wrap ? '0 : lmfc_cnt_q + 1'b1;
        sysref_done_d = sysref_done_q;
        if (!i_tx_ready) begin
            sysref_done_d = 1'b0;
        end else if (i_sysref && !sysref_q && !sysref_done_q) begin
            sysref_done_d = 1'b1;
            lmfc_cnt_d    = '0;
        end
    end

    // nsync_low_q remembers the previous synchronised sample so a one-cycle SYNC~ glitch is ignored.
    always_comb begin
        nsync_meta_d = i_nsync;
        nsync_s_d    = nsync_meta_q;
        nsync_low_d  = ~nsync_s_q;
        fall_back    = ~nsync_s_q & nsync_low_q;
    end

    always_comb begin
        state_d   = state_q;
        ilas_mf_d = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (sysref_done_q && !nsync_s_q) state_d = ST_CGS;
            end
            ST_CGS: begin
                if (nsync_s_q) state_d = ST_WAIT_LMFC;
            end
            ST_WAIT_LMFC: begin
                if (fall_back)      state_d = ST_CGS;
                else if (lmfc_wrap) state_d = ST_ILAS;
            end
            ST_ILAS: begin
                ilas_mf_d = lmfc_wrap ? ilas_mf_q + 2'd1 : ilas_mf_q;
                if (fall_back)                           state_d = ST_CGS;
                else if (lmfc_wrap && ilas_mf_q == 2'd3) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (fall_back) state_d = ST_CGS;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!i_tx_ready) begin
            state_d   = ST_IDLE;
            ilas_mf_d = 2'd0;
        end
    end

    // Handshake: o_tx_data_ready is high exactly while in DATA; every cycle it is high,
    // i_tx_data is taken at the next edge and appears on the lane one cycle later.
    always_comb begin
        tx_word_d = {4{K285}};
        txctrl_d  = 4'hF;
        case (state_q)
            ST_ILAS: begin
                tx_word_d = ilas_word;
                txctrl_d  = ilas_k;
            end
            ST_DATA: begin
                tx_word_d = i_tx_data;
                txctrl_d  = 4'h0;
            end
            default: ;
        endcase
        lmfc_pulse_d    = (lmfc_cnt_q == '0) && sysref_done_q;
        tx_data_ready_d = (state_d == ST_DATA);
    end

    always_ff @(posedge i_gtwiz_reset_clk_freerun_in or posedge i_gtwiz_reset_all_in) begin
        if (i_gtwiz_reset_all_in) begin
            sysref_q        <= 1'b0;
            sysref_done_q   <= 1'b0;
            lmfc_cnt_q      <= '0;
            nsync_meta_q    <= 1'b1;
            nsync_s_q       <= 1'b1;
            nsync_low_q     <= 1'b0;
            state_q         <= ST_IDLE;
            ilas_mf_q       <= 2'd0;
            tx_word_q       <= 32'h0;
            txctrl_q        <= 4'h0;
            lmfc_pulse_q    <= 1'b0;
            tx_data_ready_q <= 1'b0;
        end else begin
            sysref_q        <= sysref_d;
            sysref_done_q   <= sysref_done_d;
            lmfc_cnt_q      <= lmfc_cnt_d;
            nsync_meta_q    <= nsync_meta_d;
            nsync_s_q       <= nsync_s_d;
            nsync_low_q     <= nsync_low_d;
            state_q         <= state_d;
            ilas_mf_q       <= ilas_mf_d;
            tx_word_q       <= tx_word_d;
            txctrl_q        <= txctrl_d;
            lmfc_pulse_q    <= lmfc_pulse_d;
            tx_data_ready_q <= tx_data_ready_d;
        end
    end

    assign o_gtwiz_userdata_tx_in = tx_word_q;
    assign o_txctrl2              = txctrl_q;
    assign o_link_state           = state_q;
    assign o_lmfc                 = lmfc_pulse_q;
    assign o_sysref_done          = sysref_done_q;
    assign o_tx_data_ready        = tx_data_ready_q;

endmodule

// File: tb/tb_jesd204b_tx_core.sv
// Directed bench for jesd204b_tx_core with F=1, K=32 (8 words per multiframe) and non-zero config octets.
module tb_jesd204b_tx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        sysref;
    logic        nsync;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_data_ready;
    logic [31:0] tx_word;
    logic [3:0]  txctrl;
    logic [2:0]  link_state;
    logic        lmfc;
    logic        sysref_done;

    int n_cmp = 0;
    int n_bad = 0;
    int lm    = 0;

    logic [31:0] exp_w;
    logic [3:0]  exp_k;
    logic        have_w;

    always #5 clk = ~clk;

    jesd204b_tx_core #(
        .JESD_F                  (1),
        .JESD_K                  (32),
        .LMFC_CNT_WIDTH          (8),
        .JESD204B_CONFIG_DID     (8'h5A),
        .JESD204B_CONFIG_BID     (8'h03),
        .JESD204B_CONFIG_LID     (8'h00),
        .JESD204B_CONFIG_L       (8'h00),
        .JESD204B_CONFIG_F       (8'h00),
        .JESD204B_CONFIG_K       (8'h1F),
        .JESD204B_CONFIG_M       (8'h01),
        .JESD204B_CONFIG_CS_N    (8'h0F),
        .JESD204B_CONFIG_SUBV_NP (8'h2F),
        .JESD204B_CONFIG_JESDV_S (8'h20),
        .JESD204B_CONFIG_CF_HD   (8'h80)
    ) dut (
        .i_gtwiz_reset_clk_freerun_in (clk),
        .i_gtwiz_reset_all_in         (rst),
        .i_sysref                     (sysref),
        .i_nsync                      (nsync),
        .i_tx_ready                   (tx_ready),
        .i_tx_data                    (tx_data),
        .o_tx_data_ready              (tx_data_ready),
        .o_gtwiz_userdata_tx_in       (tx_word),
        .o_txctrl2                    (txctrl),
        .o_link_state                 (link_state),
        .o_lmfc                       (lmfc),
        .o_sysref_done                (sysref_done)
    );

    // lm is the expected LMFC word count after the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
        lm = (lm + 1) % 8;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        for (int n = 0; n < 24 && link_state !== st; n++) step();
        chk(tag, 32'(link_state), 32'(st));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_word"},  tx_word, 32'h0);
        chk({tag, "_ctrl"},  32'(txctrl), 32'h0);
        chk({tag, "_state"}, 32'(link_state), 32'h0);
        chk({tag, "_lmfc"},  32'(lmfc), 32'h0);
        chk({tag, "_sdone"}, 32'(sysref_done), 32'h0);
        chk({tag, "_ready"}, 32'(tx_data_ready), 32'h0);
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b0; sysref = 1'b0; nsync = 1'b1; tx_data = 32'h0;
        repeat (3) step();
        chk_reset_outputs("reset");

        rst = 1'b0; tx_ready = 1'b1;
        step();
        chk("idle_word", tx_word, 32'hBCBCBCBC);
        chk("idle_ctrl", 32'(txctrl), 32'hF);
        chk("idle_sdone", 32'(sysref_done), 32'h0);

        // SYSREF pulse and SYNC~ request together
        sysref = 1'b1; nsync = 1'b0;
        step(); lm = 0;
        chk("sysref_done", 32'(sysref_done), 32'h1);
        sysref = 1'b0;
        step();
        chk("first_lmfc", 32'(lmfc), 32'h1);
        chk("still_idle", 32'(link_state), 32'h0);
        step();
        chk("cgs_state", 32'(link_state), 32'h1);
        step();
        chk("cgs_word", tx_word, 32'hBCBCBCBC);
        chk("cgs_ctrl", 32'(txctrl), 32'hF);

        // release SYNC~ at lmfc_cnt=3; ILAS must start on the next multiframe
        nsync = 1'b1;
        step(); step(); step();
        chk("wait_state", 32'(link_state), 32'h2);
        step();
        chk("wait_word", tx_word, 32'hBCBCBCBC);
        chk("wait_lmfc", 32'(lmfc), 32'h0);
        step();
        chk("ilas_state", 32'(link_state), 32'h3);
        chk("ilas_entry_word", tx_word, 32'hBCBCBCBC);

        tx_data = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) begin
            step();
            have_w = 1'b1;
            case (i)
                0, 16:          begin exp_w = 32'h0302011C; exp_k = 4'h1; end
                1:              begin exp_w = 32'h07060504; exp_k = 4'h0; end
                7, 15, 23, 31:  begin exp_w = 32'h7C1E1D1C; exp_k = 4'h8; end
                8:              begin exp_w = 32'h035A9C1C; exp_k = 4'h3; end
                9:              begin exp_w = 32'h1F000000; exp_k = 4'h0; end
                10:             begin exp_w = 32'h202F0F01; exp_k = 4'h0; end
                11:             begin exp_w = 32'h5B000080; exp_k = 4'h0; end
                12:             begin exp_w = 32'h13121110; exp_k = 4'h0; end
                26:             begin exp_w = 32'h0B0A0908; exp_k = 4'h0; end
                default:        begin exp_w = 32'h0; exp_k = 4'h0; have_w = 1'b0; end
            endcase
            if (have_w) begin
                chk($sformatf("ilas_word%0d", i), tx_word, exp_w);
                chk($sformatf("ilas_ctrl%0d", i), 32'(txctrl), 32'(exp_k));
            end
            chk($sformatf("ilas_lmfc%0d", i), 32'(lmfc), 32'(i % 8 == 0));
            chk($sformatf("ilas_st%0d", i), 32'(link_state), (i == 31) ? 32'h4 : 32'h3);
            chk($sformatf("ilas_rdy%0d", i), 32'(tx_data_ready), 32'(i == 31));
        end

        step();
        chk("data_word0", tx_word, 32'hDEADBEEF);
        chk("data_ctrl0", 32'(txctrl), 32'h0);
        tx_data = 32'h0BADF00D;
        step();
        chk("data_word1", tx_word, 32'h0BADF00D);

        // second SYSREF edge at lmfc_cnt=5 must not move the LMFC
        for (int n = 0; n < 8 && lm != 5; n++) step();
        sysref = 1'b1;
        step();
        sysref = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            chk($sformatf("sysref2_lmfc%0d", n), 32'(lmfc), 32'(lm == 1));
        end
        chk("sysref2_state", 32'(link_state), 32'h4);

        // one-cycle SYNC~ glitch in DATA
        tx_data = 32'h11223344;
        nsync = 1'b0;
        step();
        nsync = 1'b1;
        repeat (4) step();
        chk("glitch_state", 32'(link_state), 32'h4);
        chk("glitch_word", tx_word, 32'h11223344);

        // two-cycle SYNC~ low in DATA falls back to CGS
        nsync = 1'b0;
        step(); step();
        nsync = 1'b1;
        step();
        chk("fb_pre_state", 32'(link_state), 32'h4);
        step();
        chk("fb_state", 32'(link_state), 32'h1);
        chk("fb_ready", 32'(tx_data_ready), 32'h0);
        step();
        chk("fb_word", tx_word, 32'hBCBCBCBC);
        chk("fb_ctrl", 32'(txctrl), 32'hF);

        wait_state(3'b011, "reilas_state");
        chk("reilas_align", 32'(lm), 32'h0);
        step();
        chk("reilas_word0", tx_word, 32'h0302011C);
        chk("reilas_lmfc", 32'(lmfc), 32'h1);

        // i_tx_ready drop during ILAS
        step();
        tx_ready = 1'b0;
        step();
        chk("drop_state", 32'(link_state), 32'h0);
        chk("drop_sdone", 32'(sysref_done), 32'h0);
        chk("drop_ready", 32'(tx_data_ready), 32'h0);
        step();
        chk("drop_word", tx_word, 32'hBCBCBCBC);
        chk("drop_lmfc", 32'(lmfc), 32'h0);

        // bring the link back up, then assert reset mid-ILAS without a clock edge
        tx_ready = 1'b1; sysref = 1'b1; nsync = 1'b0;
        step(); lm = 0;
        chk("resync_sdone", 32'(sysref_done), 32'h1);
        sysref = 1'b0;
        step(); step();
        chk("resync_cgs", 32'(link_state), 32'h1);
        nsync = 1'b1;
        wait_state(3'b011, "ilas3_state");
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        step();
        chk("post_rst_state", 32'(link_state), 32'h0);
        chk("post_rst_word", tx_word, 32'hBCBCBCBC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
